// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - arbitration mode encodings shared by mux_arb
package mux_pkg;
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotate-priority search starting after ptr
module rr_arbiter #(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] ptr,
    input  logic                   en,
    output logic [NCH-1:0]         gnt,
    output logic [$clog2(NCH)-1:0] gnt_idx,
    output logic                   any
);
    localparam int SELW = $clog2(NCH);

    logic [SELW-1:0] idx;

    // Walk from the farthest candidate back to ptr+1 so the nearest requester wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int k = NCH; k >= 1; k--) begin
            idx = SELW'((int'(ptr) + k) % NCH);
            if (en && req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                any      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_arb.sv
// rtl/mux_arb.sv - N-channel registered mux with fixed or round-robin arbitration
module mux_arb
    import mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic [$clog2(NCH)-1:0] s,
    input  logic [NCH-1:0]         in_valid,
    input  logic [NCH*WIDTH-1:0]   in_data,
    output logic [NCH-1:0]         in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(NCH)-1:0] out_ch,
    input  logic                   out_ready
);
    localparam int SELW = $clog2(NCH);

    logic [SELW-1:0]  ptr;
    logic [NCH-1:0]   rr_gnt;
    logic [SELW-1:0]  rr_idx;
    logic             rr_any;
    logic [NCH-1:0]   fixed_gnt;
    logic             fixed_any;
    logic [NCH-1:0]   grant;
    logic [SELW-1:0]  gidx;
    logic             any_grant;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;

    rr_arbiter #(.NCH(NCH)) u_rr (
        .req     (in_valid),
        .ptr     (ptr),
        .en      (mode == MODE_RR),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .any     (rr_any)
    );

    // Out-of-range select must not index in_valid, so it is screened first.
    always_comb begin
        fixed_gnt = '0;
        fixed_any = 1'b0;
        if (int'(s) < NCH && in_valid[s]) begin
            fixed_gnt[s] = 1'b1;
            fixed_any    = 1'b1;
        end
    end

    assign grant     = (mode == MODE_RR) ? rr_gnt : fixed_gnt;
    assign gidx      = (mode == MODE_RR) ? rr_idx : s;
    assign any_grant = (mode == MODE_RR) ? rr_any : fixed_any;
    assign load      = ~out_valid | out_ready;
    assign in_ready  = (load && !rst) ? grant : '0;
    assign xfer      = load & any_grant & ~rst;

    // One-hot AND-OR select keeps the data path free of an index decode.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) sel_data = sel_data | in_data[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= SELW'(NCH - 1);
        end else if (load) begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_ch    <= gidx;
                if (mode == MODE_RR) ptr <= gidx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mux_arb.sv
// tb/tb_mux_arb.sv - directed self-checking bench for mux_arb
module tb_mux_arb;
    logic        clk;
    logic        rst;
    logic        mode;
    logic [1:0]  s;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_ready;

    logic        mode3;
    logic [1:0]  s3;
    logic [2:0]  v3;
    logic [23:0] d3;
    logic [2:0]  rdy3;
    logic        ov3;
    logic [7:0]  od3;
    logic [1:0]  och3;
    logic        ordy3;

    int total;
    int passed;

    mux_arb #(.WIDTH(8), .NCH(4)) u4 (
        .clk(clk), .rst(rst), .mode(mode), .s(s),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready)
    );

    mux_arb #(.WIDTH(8), .NCH(3)) u3 (
        .clk(clk), .rst(rst), .mode(mode3), .s(s3),
        .in_valid(v3), .in_data(d3), .in_ready(rdy3),
        .out_valid(ov3), .out_data(od3), .out_ch(och3),
        .out_ready(ordy3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        total  = 0;
        passed = 0;

        rst       = 1'b1;
        mode      = 1'($urandom_range(0, 1));
        s         = 2'($urandom_range(0, 3));
        in_valid  = 4'($urandom_range(0, 15));
        in_data   = $urandom;
        out_ready = 1'($urandom_range(0, 1));
        mode3 = 1'b0; s3 = 2'd0; v3 = 3'b000; d3 = 24'h0; ordy3 = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        step();
        in_valid = 4'hF;
        #1;
        chk("rst_in_ready_allvalid", 32'(in_ready), 32'h0);
        step();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_ch", 32'(out_ch), 32'h0);
        chk("rst3_out_valid", 32'(ov3), 32'h0);

        rst       = 1'b0;
        mode      = 1'b0;
        s         = 2'd2;
        in_valid  = 4'b0100;
        in_data   = {8'h00, 8'hA5, 8'h00, 8'h00};
        out_ready = 1'b1;
        #1;
        chk("fix_in_ready", 32'(in_ready), 32'h4);
        step();
        chk("fix_out_valid", 32'(out_valid), 32'h1);
        chk("fix_out_data", 32'(out_data), 32'hA5);
        chk("fix_out_ch", 32'(out_ch), 32'h2);

        s3 = 2'd1; v3 = 3'b111; d3 = {8'h22, 8'h11, 8'h00};
        #1;
        chk("n3_in_ready_s1", 32'(rdy3), 32'h2);
        step();
        chk("n3_out_data", 32'(od3), 32'h11);
        chk("n3_out_valid", 32'(ov3), 32'h1);
        s3 = 2'd3;
        #1;
        chk("n3_oor_in_ready", 32'(rdy3), 32'h0);
        step();
        chk("n3_oor_out_valid", 32'(ov3), 32'h0);
        v3 = 3'b000;

        mode     = 1'b1;
        in_valid = 4'hF;
        in_data  = {8'd3, 8'd2, 8'd1, 8'd0};
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_all_in_ready", 32'(in_ready), 32'(1 << (k % 4)));
            step();
            chk("rr_all_out_ch", 32'(out_ch), 32'(k % 4));
            chk("rr_all_out_data", 32'(out_data), 32'(k % 4));
        end

        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_1010_out_ch", 32'(out_ch), (k % 2 == 0) ? 32'd3 : 32'd1);
        end

        mode     = 1'b0;
        s        = 2'd2;
        in_valid = 4'b0100;
        in_data  = {8'h00, 8'h3C, 8'h00, 8'h00};
        step();
        chk("bp_load", 32'(out_data), 32'h3C);
        out_ready = 1'b0;
        in_data   = {8'h00, 8'h77, 8'h00, 8'h00};
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            step();
            chk("bp_out_data", 32'(out_data), 32'h3C);
            chk("bp_out_valid", 32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'h4);
        step();
        chk("bp_next_word", 32'(out_data), 32'h77);

        mode     = 1'b1;
        in_valid = 4'b0010;
        in_data  = {8'd3, 8'd2, 8'd1, 8'd0};
        step();
        chk("sw_rr_ch1", 32'(out_ch), 32'h1);
        mode     = 1'b0;
        s        = 2'd0;
        in_valid = 4'hF;
        #1;
        chk("sw_fix_in_ready", 32'(in_ready), 32'h1);
        step();
        chk("sw_fix_out_ch", 32'(out_ch), 32'h0);
        mode = 1'b1;
        #1;
        chk("sw_rr_resume_in_ready", 32'(in_ready), 32'h4);
        step();
        chk("sw_rr_resume_out_ch", 32'(out_ch), 32'h2);

        out_ready = 1'b0;
        rst       = 1'b1;
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
        step();
        chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'h1);
        step();
        chk("post_rst_out_ch", 32'(out_ch), 32'h0);

        in_valid = 4'h0;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'h0);
        step();
        chk("idle_out_valid", 32'(out_valid), 32'h0);
        chk("idle_out_data_hold", 32'(out_data), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
